// File: rtl/sound_mixer.sv
// Final audio mixer: routes four channel samples per NR51, sums them with a sequential
// accumulator, applies NR50 master volume with saturation, and emits one L/R pair per strobe.
module sound_mixer #(
  parameter int SYNC_STAGES = 3
) (
  input  logic        I_BITCLK,
  input  logic        I_RESET,
  input  logic        I_STROBE,
  input  logic [19:0] I_CH1_SAMPLE,
  input  logic [19:0] I_CH2_SAMPLE,
  input  logic [19:0] I_CH3_SAMPLE,
  input  logic [19:0] I_CH4_SAMPLE,
  input  logic [7:0]  I_NR51,
  input  logic [7:0]  I_NR50,
  input  logic        I_SOUND_EN,
  output logic [19:0] O_LEFT_SAMPLE,
  output logic [19:0] O_RIGHT_SAMPLE,
  output logic        O_SAMPLE_VALID
);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, ACC3, ACC4, SCALE, OUT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][7:0] nr51_sync;
  logic [SYNC_STAGES-1:0][5:0] nr50_sync;
  logic [SYNC_STAGES-1:0]      en_sync;

  logic [3:0][19:0] ch_cap;
  logic [7:0]       nr51_snap;
  logic [2:0]       vol_l_snap, vol_r_snap;
  logic             en_snap;
  logic [21:0]      acc_l, acc_r;
  logic [19:0]      sat_l, sat_r;

  logic [1:0]  idx;
  logic [19:0] cur;
  logic [3:0]  l_mask, r_mask;
  logic [21:0] add_l, add_r;

  // VIN routing bits have no function in this mixer
  logic unused_vin;
  assign unused_vin = I_NR50[7] ^ I_NR50[3];

  always_ff @(posedge I_BITCLK) begin
    if (I_RESET) begin
      nr51_sync <= '0;
      nr50_sync <= '0;
      en_sync   <= '0;
    end else begin
      nr51_sync <= {nr51_sync[SYNC_STAGES-2:0], I_NR51};
      nr50_sync <= {nr50_sync[SYNC_STAGES-2:0], I_NR50[6:4], I_NR50[2:0]};
      en_sync   <= {en_sync[SYNC_STAGES-2:0], I_SOUND_EN};
    end
  end

  function automatic logic [19:0] scale_sat(input logic [21:0] acc, input logic [2:0] vol);
    logic signed [24:0] a, m, prod, res;
    a    = {{3{acc[21]}}, acc};
    m    = $signed({22'd0, vol}) + 25'sd1;
    prod = a * m;
    res  = prod >>> 3;
    if (res > 25'sd524287)
      return 20'h7FFFF;
    else if (res < -25'sd524288)
      return 20'h80000;
    else
      return res[19:0];
  endfunction

  always_ff @(posedge I_BITCLK) begin
    if (I_RESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx       = 2'd0;
    case (state)
      IDLE:  if (I_STROBE) state_nxt = ACC1;
      ACC1:  begin idx = 2'd0; state_nxt = ACC2; end
      ACC2:  begin idx = 2'd1; state_nxt = ACC3; end
      ACC3:  begin idx = 2'd2; state_nxt = ACC4; end
      ACC4:  begin idx = 2'd3; state_nxt = SCALE; end
      SCALE: state_nxt = OUT;
      OUT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign l_mask = nr51_snap[7:4];
  assign r_mask = nr51_snap[3:0];
  assign cur    = ch_cap[idx];
  assign add_l  = l_mask[idx] ? {{2{cur[19]}}, cur} : '0;
  assign add_r  = r_mask[idx] ? {{2{cur[19]}}, cur} : '0;

  always_ff @(posedge I_BITCLK) begin
    if (I_RESET) begin
      acc_l          <= '0;
      acc_r          <= '0;
      sat_l          <= '0;
      sat_r          <= '0;
      ch_cap         <= '0;
      nr51_snap      <= '0;
      vol_l_snap     <= '0;
      vol_r_snap     <= '0;
      en_snap        <= 1'b0;
      O_LEFT_SAMPLE  <= '0;
      O_RIGHT_SAMPLE <= '0;
      O_SAMPLE_VALID <= 1'b0;
    end else begin
      O_SAMPLE_VALID <= 1'b0;
      case (state)
        IDLE: if (I_STROBE) begin
          ch_cap     <= {I_CH4_SAMPLE, I_CH3_SAMPLE, I_CH2_SAMPLE, I_CH1_SAMPLE};
          nr51_snap  <= nr51_sync[SYNC_STAGES-1];
          vol_l_snap <= nr50_sync[SYNC_STAGES-1][5:3];
          vol_r_snap <= nr50_sync[SYNC_STAGES-1][2:0];
          en_snap    <= en_sync[SYNC_STAGES-1];
          acc_l      <= '0;
          acc_r      <= '0;
        end
        ACC1, ACC2, ACC3, ACC4: begin
          acc_l <= acc_l + add_l;
          acc_r <= acc_r + add_r;
        end
        SCALE: begin
          sat_l <= scale_sat(acc_l, vol_l_snap);
          sat_r <= scale_sat(acc_r, vol_r_snap);
        end
        OUT: begin
          O_LEFT_SAMPLE  <= en_snap ? sat_l : '0;
          O_RIGHT_SAMPLE <= en_snap ? sat_r : '0;
          O_SAMPLE_VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// Self-checking bench for sound_mixer: vector table plus hand-written sequences
// for strobe overlap, CDC timing and mid-mix reset; results checked via scoreboard.
module tb_sound_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [19:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic [7:0]  nr51 = '0, nr50 = '0;
  logic        en = 1'b0;
  logic [19:0] out_l, out_r;
  logic        valid;

  sound_mixer #(.SYNC_STAGES(3)) dut (
    .I_BITCLK(clk), .I_RESET(rst), .I_STROBE(strobe),
    .I_CH1_SAMPLE(c1), .I_CH2_SAMPLE(c2), .I_CH3_SAMPLE(c3), .I_CH4_SAMPLE(c4),
    .I_NR51(nr51), .I_NR50(nr50), .I_SOUND_EN(en),
    .O_LEFT_SAMPLE(out_l), .O_RIGHT_SAMPLE(out_r), .O_SAMPLE_VALID(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] c1, c2, c3, c4;
    logic [7:0]  nr51, nr50;
    logic        en;
    logic [19:0] el, er;
  } vec_t;

  typedef struct {
    logic [19:0] l, r;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0, n_fail = 0, n_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got L=%0h R=%0h expected no pulse", out_l, out_r);
      end else begin
        e = sb.pop_front();
        chk("left", {12'd0, out_l}, {12'd0, e.l});
        chk("right", {12'd0, out_r}, {12'd0, e.r});
      end
    end
  end

  task automatic apply(input vec_t v);
    c1 = v.c1; c2 = v.c2; c3 = v.c3; c4 = v.c4;
    nr51 = v.nr51; nr50 = v.nr50; en = v.en;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 just after the edge that sampled the strobe.
  task automatic pulse_strobe();
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (valid) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, lat, 6);
    tick(1);
    chk({name, "_valid_width"}, {31'd0, valid}, 0);
  endtask

  int v0;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{20'h02222, 20'h0, 20'h0, 20'h0, 8'h11, 8'h77, 1'b1, 20'h02222, 20'h02222};
    vecs[1]  = '{20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 8'hFF, 8'h77, 1'b1, 20'h7FFFC, 20'h7FFFC};
    vecs[2]  = '{20'hE0001, 20'hE0001, 20'hE0001, 20'hE0001, 8'hFF, 8'h77, 1'b1, 20'h80004, 20'h80004};
    vecs[3]  = '{20'hE0001, 20'h1FFFF, 20'h0, 20'h0, 8'h12, 8'h77, 1'b1, 20'hE0001, 20'h1FFFF};
    vecs[4]  = '{20'h10000, 20'h0, 20'h0, 20'h0, 8'h11, 8'h20, 1'b1, 20'h06000, 20'h02000};
    vecs[5]  = '{20'hFFFFF, 20'h0, 20'h0, 20'h0, 8'h11, 8'h00, 1'b1, 20'hFFFFF, 20'hFFFFF};
    vecs[6]  = '{20'h12345, 20'hF0000, 20'h00100, 20'hFFF00, 8'hA5, 8'h53, 1'b1, 20'hF3F40, 20'h09222};
    vecs[7]  = '{20'h12345, 20'h0, 20'h0, 20'h0, 8'hFF, 8'h77, 1'b0, 20'h00000, 20'h00000};
    vecs[8]  = '{20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 8'hFF, 8'h77, 1'b1, 20'h7FFFF, 20'h7FFFF};
    vecs[9]  = '{20'h80000, 20'h80000, 20'h80000, 20'h80000, 8'hFF, 8'h77, 1'b1, 20'h80000, 20'h80000};
    vecs[10] = '{20'h10000, 20'h0, 20'h0, 20'h0, 8'h11, 8'h88, 1'b1, 20'h02000, 20'h02000};

    rst = 1'b1;
    tick(3);
    chk("reset_left", {12'd0, out_l}, 0);
    chk("reset_right", {12'd0, out_r}, 0);
    chk("reset_valid", {31'd0, valid}, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i]);
      tick(4);
      sb.push_back('{vecs[i].el, vecs[i].er});
      pulse_strobe();
      wait_valid($sformatf("vec%0d", i));
    end

    // Second strobe lands in ACC3 and must be dropped
    apply(vecs[0]);
    tick(4);
    v0 = n_valid;
    sb.push_back('{20'h02222, 20'h02222});
    pulse_strobe();
    tick(2);
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    tick(15);
    chk("double_strobe_pulses", v0 == n_valid - 1 ? 32'd1 : 32'd0, 1);

    // Volume written one clock before the strobe must not reach this mix
    apply(vecs[4]);
    nr50 = 8'h77;
    tick(4);
    nr50 = 8'h00;
    tick(1);
    sb.push_back('{20'h10000, 20'h10000});
    pulse_strobe();
    wait_valid("nr50_late");

    // Reset sampled at E3 aborts the mix
    apply(vecs[1]);
    tick(4);
    v0 = n_valid;
    pulse_strobe();
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);
    chk("abort_pulses", n_valid - v0, 0);
    chk("abort_left", {12'd0, out_l}, 0);
    chk("abort_right", {12'd0, out_r}, 0);
    sb.push_back('{20'h7FFFC, 20'h7FFFC});
    pulse_strobe();
    wait_valid("post_reset");

    tick(5);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
